// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control/branch/table bundle for pc_sequencer (CALL_STACK_EN adds call/ret/stack_err)
interface pc_sequencer_if #(parameter int D = 10, parameter int N_ENT = 16);
   localparam int IW = $clog2(N_ENT);

   logic          start;
   logic          stall;
   logic          halt_req;
   logic          br_taken;
   logic          br_rel;
   logic [IW-1:0] br_idx;
   logic          tbl_we;
   logic [IW-1:0] tbl_waddr;
   logic [D-1:0]  tbl_wdata;
   logic [D-1:0]  prog_pc;
   logic          running;
   logic          done;
`ifdef CALL_STACK_EN
   logic          call;
   logic          ret;
   logic          stack_err;

   modport master (output start, stall, halt_req, br_taken, br_rel, br_idx,
                   output tbl_we, tbl_waddr, tbl_wdata, call, ret,
                   input  prog_pc, running, done, stack_err);
   modport slave  (input  start, stall, halt_req, br_taken, br_rel, br_idx,
                   input  tbl_we, tbl_waddr, tbl_wdata, call, ret,
                   output prog_pc, running, done, stack_err);
`else
   modport master (output start, stall, halt_req, br_taken, br_rel, br_idx,
                   output tbl_we, tbl_waddr, tbl_wdata,
                   input  prog_pc, running, done);
   modport slave  (input  start, stall, halt_req, br_taken, br_rel, br_idx,
                   input  tbl_we, tbl_waddr, tbl_wdata,
                   output prog_pc, running, done);
`endif
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with jump table; optional return stack via CALL_STACK_EN
module pc_sequencer #(
   parameter int D     = 10,
   parameter int N_ENT = 16
) (
   input logic           clk,
   input logic           reset,
   pc_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t       state, state_nxt;
   logic [D-1:0] pc, pc_nxt;
   logic [D-1:0] tbl [N_ENT];
   logic [D-1:0] tbl_rd;
   logic         running_q, done_q;

   // Branches see the entry as it was before any same-edge write.
   assign tbl_rd = tbl[bus.br_idx];

`ifdef CALL_STACK_EN
   logic [D-1:0] stk [4];
   logic [1:0]   sp;      // next push slot; when full it points at the oldest entry
   logic [2:0]   cnt;
   logic         push, pop, clr_stk, err_set, stack_err_q;
`endif

   // Next-state and next-PC selection, stall > halt > (ret > call >) branch > increment.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
`ifdef CALL_STACK_EN
      push    = 1'b0;
      pop     = 1'b0;
      clr_stk = 1'b0;
      err_set = 1'b0;
`endif
      case (state)
         IDLE: begin
            pc_nxt = '0;
            if (bus.start) state_nxt = RUN;
         end
         RUN: begin
            if (!bus.stall) begin
               if (bus.halt_req) begin
                  state_nxt = HALT;
               end
`ifdef CALL_STACK_EN
               else if (bus.ret) begin
                  pop = 1'b1;
                  if (cnt == 3'd0) begin
                     pc_nxt  = pc + D'(1);
                     err_set = 1'b1;
                  end else begin
                     pc_nxt = stk[sp - 2'd1];
                  end
               end else if (bus.call) begin
                  push    = 1'b1;
                  err_set = (cnt == 3'd4);
                  pc_nxt  = tbl_rd;
               end
`endif
               else if (bus.br_taken) begin
                  pc_nxt = bus.br_rel ? pc + tbl_rd : tbl_rd;
               end else begin
                  pc_nxt = pc + D'(1);
               end
            end
         end
         HALT: begin
            if (bus.start) begin
               state_nxt = RUN;
               pc_nxt    = '0;
`ifdef CALL_STACK_EN
               clr_stk   = 1'b1;
`endif
            end
         end
         default: begin
            state_nxt = IDLE;
            pc_nxt    = '0;
         end
      endcase
   end

   // State, PC and registered state decodes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pc        <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         running_q <= (state_nxt == RUN);
         done_q    <= (state_nxt == HALT);
      end
   end

   // Jump table: cleared by reset, written in any state otherwise.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_ENT; i++) tbl[i] <= '0;
      end else if (bus.tbl_we) begin
         tbl[bus.tbl_waddr] <= bus.tbl_wdata;
      end
   end

`ifdef CALL_STACK_EN
   // Circular return stack; overflow overwrites the oldest entry, errors are sticky.
   always_ff @(posedge clk) begin
      if (reset) begin
         sp          <= '0;
         cnt         <= '0;
         stack_err_q <= 1'b0;
         for (int i = 0; i < 4; i++) stk[i] <= '0;
      end else begin
         if (err_set) stack_err_q <= 1'b1;
         if (clr_stk) begin
            sp  <= '0;
            cnt <= '0;
         end else if (push) begin
            stk[sp] <= pc + D'(1);
            sp      <= sp + 2'd1;
            if (cnt != 3'd4) cnt <= cnt + 3'd1;
         end else if (pop && cnt != 3'd0) begin
            sp  <= sp - 2'd1;
            cnt <= cnt - 3'd1;
         end
      end
   end

   assign bus.stack_err = stack_err_q;
`endif

   assign bus.prog_pc = pc;
   assign bus.running = running_q;
   assign bus.done    = done_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - vector table plus scoreboard bench for pc_sequencer
module tb_pc_sequencer;
   logic clk;
   logic reset;

   pc_sequencer_if #(.D(10), .N_ENT(16)) bus ();

   pc_sequencer #(.D(10), .N_ENT(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst, st, stl, hlt, bt, rel;
      logic [3:0] idx;
      logic       we;
      logic [3:0] wa;
      logic [9:0] wd;
      logic [9:0] epc;
      logic       erun, edone;
   } vec_t;

   typedef struct {
      logic [9:0] pc;
      logic       run, done;
      int         tag;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   total  = 0;
   int   passed = 0;

   function automatic vec_t v(input logic rst, st, stl, hlt, bt, rel, input logic [3:0] idx,
                              input logic we, input logic [3:0] wa, input logic [9:0] wd,
                              input logic [9:0] epc, input logic erun, edone);
      vec_t r;
      r.rst = rst; r.st = st; r.stl = stl; r.hlt = hlt; r.bt = bt; r.rel = rel;
      r.idx = idx; r.we = we; r.wa = wa; r.wd = wd;
      r.epc = epc; r.erun = erun; r.edone = edone;
      return r;
   endfunction

   task automatic chk(input string nm, input int tag, input logic [9:0] act, input logic [9:0] expv);
      total++;
      if (act === expv) passed++;
      else $display("FAIL %s step %0d: got %h expected %h", nm, tag, act, expv);
   endtask

   task automatic step(input vec_t x, input int tag);
      exp_t e;
      @(negedge clk);
      reset        = x.rst;
      bus.start    = x.st;
      bus.stall    = x.stl;
      bus.halt_req = x.hlt;
      bus.br_taken = x.bt;
      bus.br_rel   = x.rel;
      bus.br_idx   = x.idx;
      bus.tbl_we   = x.we;
      bus.tbl_waddr = x.wa;
      bus.tbl_wdata = x.wd;
      exp_q.push_back('{pc: x.epc, run: x.erun, done: x.edone, tag: tag});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         total++;
         $display("FAIL scoreboard step %0d: got empty queue expected entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk("prog_pc", e.tag, bus.prog_pc, e.pc);
         chk("running", e.tag, {9'd0, bus.running}, {9'd0, e.run});
         chk("done", e.tag, {9'd0, bus.done}, {9'd0, e.done});
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.start = 0; bus.stall = 0; bus.halt_req = 0; bus.br_taken = 0; bus.br_rel = 0;
      bus.br_idx = '0; bus.tbl_we = 0; bus.tbl_waddr = '0; bus.tbl_wdata = '0;
`ifdef CALL_STACK_EN
      bus.call = 0; bus.ret = 0;
`endif
      //                rst st stl hlt bt rel idx we wa wd       pc     run done
      vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h001, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h002, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h003, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h004, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 7, 10'h155, 10'h005, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, 10'h3FF, 10'h006, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 3, 10'h3FB, 10'h007, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 1, 0, 7, 0, 0, 10'h000, 10'h155, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 1, 0, 1, 0, 0, 10'h000, 10'h3FF, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 4, 10'h014, 10'h001, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 1, 0, 4, 0, 0, 10'h000, 10'h014, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 1, 1, 3, 0, 0, 10'h000, 10'h00F, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h010, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 6, 10'h005, 10'h011, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 1, 0, 1, 0, 0, 10'h000, 10'h3FF, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 1, 1, 6, 0, 0, 10'h000, 10'h004, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h005, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h006, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h007, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h008, 1, 0));
      vecs.push_back(v(0, 0, 1, 1, 0, 0, 0, 0, 0, 10'h000, 10'h008, 1, 0));
      vecs.push_back(v(0, 0, 1, 1, 0, 0, 0, 0, 0, 10'h000, 10'h008, 1, 0));
      vecs.push_back(v(0, 0, 1, 1, 0, 0, 0, 0, 0, 10'h000, 10'h008, 1, 0));
      vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 10'h000, 10'h008, 0, 1));
      vecs.push_back(v(0, 0, 1, 1, 1, 0, 7, 0, 0, 10'h000, 10'h008, 0, 1));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h008, 0, 1));
      vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h001, 1, 0));
      vecs.push_back(v(0, 0, 1, 0, 1, 0, 7, 0, 0, 10'h000, 10'h001, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 1, 0, 7, 0, 0, 10'h000, 10'h155, 1, 0));
      vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h156, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 2, 10'h010, 10'h157, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 1, 0, 2, 1, 2, 10'h040, 10'h010, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h011, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 1, 0, 2, 0, 0, 10'h000, 10'h040, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 4, 10'h012, 10'h041, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 5, 10'h0AA, 10'h042, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 1, 0, 4, 0, 0, 10'h000, 10'h012, 1, 0));
      vecs.push_back(v(1, 0, 0, 0, 1, 0, 5, 1, 6, 10'h001, 10'h000, 0, 0));
      vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 1, 0, 5, 0, 0, 10'h000, 10'h000, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 1, 0, 6, 0, 0, 10'h000, 10'h000, 1, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h001, 1, 0));

      for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

      // Halt straight from RUN, restart from HALT, halt again, then reset out of HALT.
      step(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 10'h000, 10'h001, 0, 1), 100);
      step(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0), 101);
      step(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h001, 1, 0), 102);
      step(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 10'h000, 10'h001, 0, 1), 103);
      step(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0), 104);
      step(v(0, 0, 0, 0, 1, 0, 7, 0, 0, 10'h000, 10'h000, 0, 0), 105);

      chk("scoreboard_drained", 999, 10'(exp_q.size()), 10'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
